// File: rtl/addersub_pkg.sv
// addersub_pkg
//   Shared constants for the addersub operand stage: op encodings,
//   forward-select codes, immediate width, and a legal-op helper.
package addersub_pkg;

  localparam logic [2:0] OP_SUBU = 3'd0;
  localparam logic [2:0] OP_ADDU = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_ADD  = 3'd3;
  localparam logic [2:0] OP_SLTU = 3'd4;
  localparam logic [2:0] OP_SLT  = 3'd6;

  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_EX = 2'd1;
  localparam logic [1:0] FWD_WB = 2'd2;

  localparam int IMM_W = 16;

  // Codes 5 and 7 have no addersub meaning.
  function automatic logic op_is_legal(input logic [2:0] op_code);
    logic legal;
    case (op_code)
      OP_SUBU, OP_ADDU, OP_SUB, OP_ADD, OP_SLTU, OP_SLT: legal = 1'b1;
      default:                                           legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/operand_fwd_mux.sv
// operand_fwd_mux
//   Combinational operand source select.
//   sel     : FWD_RF / FWD_EX / FWD_WB; the reserved code selects rf_data
//   rf_data : register-file read value
//   ex_data : execute-stage result
//   wb_data : writeback-stage data
//   dout    : selected operand
module operand_fwd_mux
  import addersub_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] rf_data,
  input  logic [WIDTH-1:0] ex_data,
  input  logic [WIDTH-1:0] wb_data,
  output logic [WIDTH-1:0] dout
);

  always_comb begin
    dout = rf_data;
    case (sel)
      FWD_EX:  dout = ex_data;
      FWD_WB:  dout = wb_data;
      default: dout = rf_data;
    endcase
  end

endmodule

// File: rtl/addersub_opstage.sv
// addersub_opstage
//   Operand-capture stage ahead of the addersub unit. Resolves forwarding
//   for both operands, substitutes a sign-extended immediate on B, and
//   registers opA/opB/op/valid with advance, hold and squash control.
//   clk, reset          : clock, synchronous active-high reset
//   en, squash          : advance / kill incoming instruction
//   in_valid, op_in     : incoming instruction valid and op code
//   rs_data, rt_data    : register-file reads
//   imm16, use_imm      : immediate and B-source override
//   rs_fwd_sel, rt_fwd_sel, ex_result, wb_data : forwarding controls/data
//   opA, opB, op, valid_out, illegal_op        : registered stage outputs
//   stall_count         : saturating count of held-valid cycles
module addersub_opstage
  import addersub_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 squash,
  input  logic                 in_valid,
  input  logic [2:0]           op_in,
  input  logic [WIDTH-1:0]     rs_data,
  input  logic [WIDTH-1:0]     rt_data,
  input  logic [IMM_W-1:0]     imm16,
  input  logic                 use_imm,
  input  logic [1:0]           rs_fwd_sel,
  input  logic [1:0]           rt_fwd_sel,
  input  logic [WIDTH-1:0]     ex_result,
  input  logic [WIDTH-1:0]     wb_data,
  output logic [WIDTH-1:0]     opA,
  output logic [WIDTH-1:0]     opB,
  output logic [2:0]           op,
  output logic                 valid_out,
  output logic                 illegal_op,
  output logic [CNT_WIDTH-1:0] stall_count
);

  logic [WIDTH-1:0] mux_a;
  logic [WIDTH-1:0] mux_b;
  logic [WIDTH-1:0] imm_ext;
  logic [WIDTH-1:0] opb_next;

  operand_fwd_mux #(.WIDTH(WIDTH)) u_mux_a (
    .sel     (rs_fwd_sel),
    .rf_data (rs_data),
    .ex_data (ex_result),
    .wb_data (wb_data),
    .dout    (mux_a)
  );

  operand_fwd_mux #(.WIDTH(WIDTH)) u_mux_b (
    .sel     (rt_fwd_sel),
    .rf_data (rt_data),
    .ex_data (ex_result),
    .wb_data (wb_data),
    .dout    (mux_b)
  );

  assign imm_ext  = {{(WIDTH-IMM_W){imm16[IMM_W-1]}}, imm16};
  assign opb_next = use_imm ? imm_ext : mux_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      opA         <= '0;
      opB         <= '0;
      op          <= '0;
      valid_out   <= 1'b0;
      illegal_op  <= 1'b0;
      stall_count <= '0;
    end else if (squash) begin
      // Operands still load; they are meaningless for the bubble.
      opA        <= mux_a;
      opB        <= opb_next;
      op         <= '0;
      valid_out  <= 1'b0;
      illegal_op <= 1'b0;
    end else if (en) begin
      opA        <= mux_a;
      opB        <= opb_next;
      op         <= op_in;
      valid_out  <= in_valid;
      illegal_op <= in_valid & ~op_is_legal(op_in);
    end else if (valid_out && (stall_count != {CNT_WIDTH{1'b1}})) begin
      stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_addersub_opstage.sv
module tb_addersub_opstage;

  localparam int W    = 32;
  localparam int CW   = 4;
  localparam int CMAX = 15;

  logic          clk = 1'b0;
  logic          reset, en, squash, in_valid, use_imm;
  logic [2:0]    op_in;
  logic [W-1:0]  rs_data, rt_data, ex_result, wb_data;
  logic [15:0]   imm16;
  logic [1:0]    rs_fwd_sel, rt_fwd_sel;
  logic [W-1:0]  opA, opB;
  logic [2:0]    op;
  logic          valid_out, illegal_op;
  logic [CW-1:0] stall_count;

  int n_checks = 0;
  int n_fail   = 0;

  // reference state
  logic [W-1:0] m_a, m_b;
  logic [2:0]   m_op;
  logic         m_valid, m_ill;
  int           m_cnt;

  addersub_opstage #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .squash      (squash),
    .in_valid    (in_valid),
    .op_in       (op_in),
    .rs_data     (rs_data),
    .rt_data     (rt_data),
    .imm16       (imm16),
    .use_imm     (use_imm),
    .rs_fwd_sel  (rs_fwd_sel),
    .rt_fwd_sel  (rt_fwd_sel),
    .ex_result   (ex_result),
    .wb_data     (wb_data),
    .opA         (opA),
    .opB         (opB),
    .op          (op),
    .valid_out   (valid_out),
    .illegal_op  (illegal_op),
    .stall_count (stall_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] pick(input logic [1:0] sel, input logic [W-1:0] rf);
    if (sel == 2'd1) return ex_result;
    if (sel == 2'd2) return wb_data;
    return rf;
  endfunction

  function automatic logic [W-1:0] sext16(input logic [15:0] v);
    logic [W-1:0] r;
    r = 32'(v);
    if (v >= 16'h8000) r = r + 32'hFFFF_0000;
    return r;
  endfunction

  function automatic logic legal(input logic [2:0] c);
    return !(c == 3'd5 || c == 3'd7);
  endfunction

  // One clock: update the reference from the inputs in force at the edge,
  // then compare every output 1 time unit later.
  task automatic tick();
    logic [W-1:0] na, nb;
    @(posedge clk);
    na = pick(rs_fwd_sel, rs_data);
    nb = use_imm ? sext16(imm16) : pick(rt_fwd_sel, rt_data);
    if (reset) begin
      m_a = '0; m_b = '0; m_op = '0; m_valid = 1'b0; m_ill = 1'b0; m_cnt = 0;
    end else if (squash) begin
      m_a = na; m_b = nb; m_op = '0; m_valid = 1'b0; m_ill = 1'b0;
    end else if (en) begin
      m_a = na; m_b = nb; m_op = op_in; m_valid = in_valid;
      m_ill = in_valid && !legal(op_in);
    end else if (m_valid && m_cnt < CMAX) begin
      m_cnt++;
    end
    #1;
    check("opA", opA, m_a);
    check("opB", opB, m_b);
    check("op", 32'(op), 32'(m_op));
    check("valid_out", 32'(valid_out), 32'(m_valid));
    check("illegal_op", 32'(illegal_op), 32'(m_ill));
    check("stall_count", 32'(stall_count), 32'(m_cnt));
  endtask

  initial begin
    reset = 1'b1; en = 1'b1; squash = 1'b0; in_valid = 1'b0; use_imm = 1'b0;
    op_in = '0; rs_data = '0; rt_data = '0; ex_result = '0; wb_data = '0;
    imm16 = '0; rs_fwd_sel = '0; rt_fwd_sel = '0;
    m_a = '0; m_b = '0; m_op = '0; m_valid = 1'b0; m_ill = 1'b0; m_cnt = 0;

    // reset then idle
    tick(); tick();
    check("rst_opA", opA, 32'h0);
    check("rst_valid", 32'(valid_out), 32'h0);
    check("rst_cnt", 32'(stall_count), 32'h0);
    reset = 1'b0;
    tick();

    // immediate sign extension
    in_valid = 1'b1; op_in = 3'd3; rs_data = 32'h5; imm16 = 16'hFFFE; use_imm = 1'b1;
    tick();
    check("imm_neg_opA", opA, 32'h0000_0005);
    check("imm_neg_opB", opB, 32'hFFFF_FFFE);
    check("imm_neg_op", 32'(op), 32'd3);
    imm16 = 16'h7FFF;
    tick();
    check("imm_pos_opB", opB, 32'h0000_7FFF);

    // forwarding paths and reserved select
    use_imm = 1'b0; rs_fwd_sel = 2'd1; ex_result = 32'h1234_5678;
    rt_fwd_sel = 2'd2; wb_data = 32'hA5A5_A5A5; op_in = 3'd6;
    tick();
    check("fwd_opA", opA, 32'h1234_5678);
    check("fwd_opB", opB, 32'hA5A5_A5A5);
    check("fwd_op", 32'(op), 32'd6);
    rs_fwd_sel = 2'd3; rs_data = 32'h11; rt_fwd_sel = 2'd3; rt_data = 32'h22;
    tick();
    check("rsv_opA", opA, 32'h11);
    check("rsv_opB", opB, 32'h22);

    // hold with changing forward sources
    reset = 1'b1; tick(); reset = 1'b0;
    rs_fwd_sel = 2'd0; rs_data = 32'h100; op_in = 3'd1; in_valid = 1'b1;
    tick();
    en = 1'b0; rs_fwd_sel = 2'd1;
    for (int i = 0; i < 3; i++) begin
      ex_result = (i % 2 == 0) ? 32'hDEAD_BEEF : 32'h0BAD_F00D;
      tick();
    end
    check("hold_opA", opA, 32'h100);
    check("hold_cnt", 32'(stall_count), 32'd3);
    en = 1'b1;
    tick();
    check("resume_opA", opA, ex_result);

    // squash beats en, then illegal op flagged on capture
    squash = 1'b1; op_in = 3'd7;
    tick();
    check("sq_valid", 32'(valid_out), 32'd0);
    check("sq_ill", 32'(illegal_op), 32'd0);
    squash = 1'b0; op_in = 3'd5;
    tick();
    check("ill_flag", 32'(illegal_op), 32'd1);
    check("ill_op", 32'(op), 32'd5);

    // saturation, then reset mid-stall
    en = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check("sat_cnt", 32'(stall_count), 32'd15);
    reset = 1'b1;
    tick();
    check("rst_stall_valid", 32'(valid_out), 32'd0);
    check("rst_stall_cnt", 32'(stall_count), 32'd0);
    reset = 1'b0;

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      reset      = ($urandom_range(0, 99) < 2);
      squash     = ($urandom_range(0, 99) < 10);
      en         = ($urandom_range(0, 99) < 65);
      in_valid   = ($urandom_range(0, 99) < 80);
      use_imm    = $urandom_range(0, 1) == 1;
      op_in      = 3'($urandom_range(0, 7));
      rs_data    = $urandom;
      rt_data    = $urandom;
      ex_result  = $urandom;
      wb_data    = $urandom;
      imm16      = 16'($urandom);
      rs_fwd_sel = 2'($urandom_range(0, 3));
      rt_fwd_sel = 2'($urandom_range(0, 3));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
